// File: rtl/keypad_event_fifo.sv
// Debounces raw keypad scan codes into single key-press events and buffers
// the accepted hex values in a show-ahead FIFO drained by valid/ready.
module keypad_event_fifo #(
  parameter int PRESS_CYCLES   = 3,
  parameter int RELEASE_CYCLES = 3,
  parameter int DEPTH          = 4,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] scan_code,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       fifo_full,
  output logic       overflow,
  output logic       held
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PRESS   = CNT_W'(PRESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_RELEASE = CNT_W'(RELEASE_CYCLES);
  localparam logic [AW:0]      COUNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      COUNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE     = AW'(1);

  logic [1:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       cand_r, cand_s;
  logic             push_s;

  logic [3:0]       mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r;
  logic             overflow_r;
  logic             pop_s, full_s, do_push_s;

  logic             idle_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign idle_s    = scan_code[4];
  assign cnt_inc_s = cnt_r + CNT_ONE;

  // Debounce FSM next-state, counter and candidate logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    cand_s  = cand_r;
    push_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!idle_s) begin
          state_s = PRESS_WAIT;
          cand_s  = scan_code[3:0];
          cnt_s   = CNT_ONE;
        end else begin
          state_s = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (idle_s) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (scan_code[3:0] != cand_r) begin
          cand_s = scan_code[3:0];
          cnt_s  = CNT_ONE;
        end else if (cnt_inc_s == CNT_PRESS) begin
          push_s  = 1'b1;
          state_s = HELD;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      HELD: begin
        if (idle_s) begin
          state_s = RELEASE_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = HELD;
        end
      end
      RELEASE_WAIT: begin
        if (!idle_s) begin
          // Release bounce: fall back without generating an event.
          state_s = HELD;
          cnt_s   = '0;
        end else if (cnt_inc_s == CNT_RELEASE) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Debounce FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      cand_r  <= 4'h0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      cand_r  <= cand_s;
    end
  end

  // A push into a full FIFO still lands when the head is popped on the same edge.
  assign full_s    = (count_r == COUNT_FULL);
  assign pop_s     = (count_r != '0) & key_ready;
  assign do_push_s = push_s & (~full_s | pop_s);

  // FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 4'h0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= cand_r;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign key_code  = mem_r[rd_ptr_r];
  assign key_valid = (count_r != '0);
  assign fifo_full = full_s;
  assign overflow  = overflow_r;
  assign held      = (state_r == HELD) || (state_r == RELEASE_WAIT);

endmodule

// File: doc/keypad_event_fifo.md
# keypad_event_fifo

Converts the raw 5-bit code from the keypad scanner FSM into clean, single-count key-press events and buffers them for the digit display logic. A code is accepted only after it holds stable for PRESS_CYCLES consecutive samples. The block then re-arms only after the keypad has reported idle for RELEASE_CYCLES consecutive samples. Accepted key values go into a small FIFO drained through a valid/ready handshake.

## Interface
Parameters:
- PRESS_CYCLES, default 3: consecutive matching samples needed to accept a press; legal range ≥2.
- RELEASE_CYCLES, default 3: consecutive idle samples needed to re-arm; legal range ≥2.
- DEPTH, default 4: FIFO entries; must be a power of 2, ≥2.
- CNT_W, default 24: stability counter width; must hold max(PRESS_CYCLES, RELEASE_CYCLES).

Ports:
- clk, input, 1: system clock (24 MHz oscillator).
- reset, input, 1: one clock; reset is synchronous and active-high.
- scan_code, input, 5: bit4=1 means no key; bit4=0 means key pressed, with [3:0] the hex key value.
- key_code, output, 4: hex value at the FIFO head; valid only while key_valid=1.
- key_valid, output, 1: FIFO non-empty.
- key_ready, input, 1: consumer accepts the head entry on this cycle when key_valid=1.
- fifo_full, output, 1: FIFO holds DEPTH entries.
- overflow, output, 1: sticky; set when an accepted press is dropped because the FIFO is full.
- held, output, 1: a press has been accepted and the block has not yet re-armed.

## Operation
State machine with four states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. It uses a counter `cnt` (CNT_W bits) and a candidate register `cand` (4 bits).
- IDLE:
  - scan_code[4]=0 → PRESS_WAIT, cand=scan_code[3:0], cnt=1.
  - Otherwise stay in IDLE.
- PRESS_WAIT:
  - scan_code[4]=1 → IDLE, cnt=0.
  - scan_code[3:0]≠cand → stay; cand=new code, cnt=1 (restart).
  - Matching sample with cnt+1==PRESS_CYCLES → push cand, go to HELD, cnt=0.
  - Any other matching sample → cnt+1.
- HELD:
  - Any non-idle code, including a different key, → stay; no new event.
  - Idle code → RELEASE_WAIT, cnt=1.
- RELEASE_WAIT:
  - Non-idle code → HELD (bounce; no event).
  - Idle code with cnt+1==RELEASE_CYCLES → IDLE.
  - Any other idle code → cnt+1.
- held=1 in HELD and RELEASE_WAIT; 0 otherwise.
- FIFO:
  - Storage is DEPTH×4 bits; read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter is log2(DEPTH)+1 bits.
  - Push = the accept event. Pop = key_valid & key_ready.
  - key_code = mem[rd_ptr] (show-ahead). key_valid = (count≠0). fifo_full = (count==DEPTH).
  - Push when full with no pop: entry dropped, overflow←1, pointers and count unchanged.
  - Push when full with a pop in the same cycle: push accepted; count stays DEPTH.
  - Push and pop on a non-full, non-empty FIFO: both performed; count unchanged.
  - Pop when empty: ignored; key_ready is don't-care while key_valid=0.
  - No bypass: a push into an empty FIFO is not visible until the next cycle.
- overflow clears only on reset.

## Timing
- Reset is synchronous and has priority over every other action. At the first rising edge with reset=1:
  - state=IDLE, cnt=0, cand=0, pointers=0, count=0, all mem entries=0.
  - Outputs: key_valid=0, key_code=0, fifo_full=0, overflow=0, held=0.
- Reset asserted mid-press or mid-release discards partial progress. Reset asserted with a non-empty FIFO discards all buffered entries.
- Press latency: if the PRESS_CYCLES-th consecutive matching code is sampled at edge t, then after edge t:
  - held=1;
  - key_valid=1 (if the FIFO was empty);
  - key_code=cand.
- A minimum-length press therefore produces key_valid PRESS_CYCLES cycles after scan_code first goes non-idle.
- Re-arm: the earliest next accept is RELEASE_CYCLES+PRESS_CYCLES sampled cycles after the first idle sample.
- A pop at edge t updates key_code/key_valid after edge t. key_valid and key_code are registered-state derived and are stable for the whole cycle.

## Test plan
- **Clean press:** reset, then scan_code=5'b00101 for 5 cycles, then 5'b10000 → key_valid rises after the 3rd sample with key_code=5 and held=1; exactly one entry; held falls 3 idle cycles after release.
- **Glitch rejection:** codes 0x07, 0x07, 0x09, 0x09, 0x09, then idle → one event, key_code=9; no 7 ever enqueued.
- **Release bounce:** accept key A; then idle, key A, idle, idle, idle → single event; held stays 1 until 3 consecutive idles.
- **Overflow:** key_ready=0; accept keys 1, 2, 3, 4, 5 → fifo_full=1 after the 4th; 5th dropped; overflow=1; draining with key_ready=1 yields 1, 2, 3, 4 in order.
- **Simultaneous push/pop at full:** FIFO full with keys 1–4; key_ready=1 on the same edge as the accept of key 6 → count stays 4; drain order 2, 3, 4, 6; overflow stays 0.
- **Reset mid-operation:** 2 buffered entries and a press in PRESS_WAIT; pulse reset for 1 cycle → all outputs 0 next cycle; a subsequent 3-cycle press of F yields key_code=F.
